// File: rtl/demux_pkg.sv
// Shared types and sizing helpers for the demux scheduler slice.
package demux_pkg;

  typedef enum logic {
    CH0 = 1'b0,
    CH1 = 1'b1
  } sel_e;

  // Burst counter width; a BURST of 1 still needs a 1-bit register.
  function automatic int cnt_w(input int burst);
    return (burst <= 1) ? 1 : $clog2(burst);
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output holding register with valid/ready drain; a load wins over a same-cycle drain.
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_scheduler.sv
// Routes a valid/ready stream to two holding slots in fixed bursts, toggling the select after BURST accepts or on flush.
module demux_scheduler
  import demux_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out0_valid,
  output logic [WIDTH-1:0] out0_data,
  input  logic             out0_ready,
  output logic             out1_valid,
  output logic [WIDTH-1:0] out1_data,
  input  logic             out1_ready,
  output logic             sel,
  input  logic             flush
);

  localparam int CW = cnt_w(BURST);
  localparam logic [CW-1:0] LAST = CW'(BURST - 1);

  sel_e          sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          acc;

  assign in_ready = (sel_q == CH0) ? (!out0_valid || out0_ready)
                                   : (!out1_valid || out1_ready);
  assign acc = in_valid && in_ready;
  assign sel = (sel_q == CH1);

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q <= CH0;
      cnt_q <= '0;
    end else begin
      sel_q <= sel_d;
      cnt_q <= cnt_d;
    end
  end

  // Flush overrides the wrap logic, so a flush coinciding with the last word toggles only once.
  always_comb begin
    sel_d = sel_q;
    cnt_d = cnt_q;
    if (acc) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        sel_d = (sel_q == CH0) ? CH1 : CH0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (flush) begin
      cnt_d = '0;
      sel_d = (sel_q == CH0) ? CH1 : CH0;
    end
  end

  demux_slot #(.WIDTH(WIDTH)) u_slot0 (
    .clk       (clk),
    .rst       (rst),
    .load      (acc && (sel_q == CH0)),
    .load_data (in_data),
    .ready     (out0_ready),
    .valid     (out0_valid),
    .data      (out0_data)
  );

  demux_slot #(.WIDTH(WIDTH)) u_slot1 (
    .clk       (clk),
    .rst       (rst),
    .load      (acc && (sel_q == CH1)),
    .load_data (in_data),
    .ready     (out1_ready),
    .valid     (out1_valid),
    .data      (out1_data)
  );

endmodule

// File: tb/tb_demux_scheduler.sv
// Scoreboard bench for demux_scheduler: directed words with hand-assigned channels, monitor checks drained words.
module tb_demux_scheduler;

  localparam int WIDTH = 4;
  localparam int BURST = 4;

  logic             clk = 1'b0;
  logic             rst, in_valid, in_ready, flush, sel;
  logic             out0_valid, out0_ready, out1_valid, out1_ready;
  logic [WIDTH-1:0] in_data, out0_data, out1_data;

  int passed = 0;
  int total  = 0;
  logic [WIDTH-1:0] exp0[$];
  logic [WIDTH-1:0] exp1[$];

  always #5 clk = ~clk;

  demux_scheduler #(.WIDTH(WIDTH), .BURST(BURST)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out0_valid (out0_valid),
    .out0_data  (out0_data),
    .out0_ready (out0_ready),
    .out1_valid (out1_valid),
    .out1_data  (out1_data),
    .out1_ready (out1_ready),
    .sel        (sel),
    .flush      (flush)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Monitor: every completed output handshake must match the oldest expected word of that channel.
  always @(negedge clk) begin
    if (!rst) begin
      if (out0_valid && out0_ready) begin
        if (exp0.size() == 0) check("out0_spurious_word", 32'(out0_data), 32'hFFFF_FFFF);
        else check("out0_data", 32'(out0_data), 32'(exp0.pop_front()));
      end
      if (out1_valid && out1_ready) begin
        if (exp1.size() == 0) check("out1_spurious_word", 32'(out1_data), 32'hFFFF_FFFF);
        else check("out1_data", 32'(out1_data), 32'(exp1.pop_front()));
      end
    end
  end

  // Offer one word; ch is the hand-computed destination, now demands acceptance on the first cycle.
  task automatic send(input logic [WIDTH-1:0] d, input logic ch, input bit now);
    int waited = 0;
    bit done = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        check("sel_at_accept", 32'(sel), 32'(ch));
        if (now) check("no_bubble", 32'(waited), 0);
        if (ch) exp1.push_back(d);
        else exp0.push_back(d);
        done = 1;
      end else begin
        waited++;
        if (waited > 20) begin
          check("accept_timeout", 0, 1);
          done = 1;
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (ch) begin
      check("out1_valid_latency", 32'(out1_valid), 1);
      check("out1_data_latency", 32'(out1_data), 32'(d));
    end else begin
      check("out0_valid_latency", 32'(out0_valid), 1);
      check("out0_data_latency", 32'(out0_data), 32'(d));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0;
    out0_ready = 1'b1; out1_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_sel", 32'(sel), 0);
    check("rst_out0_valid", 32'(out0_valid), 0);
    check("rst_out1_valid", 32'(out1_valid), 0);
    check("rst_out0_data", 32'(out0_data), 0);
    check("rst_out1_data", 32'(out1_data), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;

    // Streaming 1..8: first burst to out0, second to out1, no bubble at the toggle
    for (int i = 1; i <= 8; i++) send(WIDTH'(i), (i > 4), 1'b1);
    idle(2);
    check("sel_after_stream", 32'(sel), 0);

    // Backpressure on channel 0
    out0_ready = 1'b0;
    send(4'hA, 1'b0, 1'b0);
    @(negedge clk);
    check("in_ready_stalled", 32'(in_ready), 0);
    check("out0_held_A", 32'(out0_data), 32'hA);
    @(posedge clk); #1;
    fork
      send(4'hB, 1'b0, 1'b0);
      begin
        repeat (2) @(posedge clk);
        #1 out0_ready = 1'b1;
      end
    join
    idle(1);

    // Independent drain: out0 holds 0x3 while channel 1 takes 0x9
    send(4'h2, 1'b0, 1'b1);
    idle(1);
    out0_ready = 1'b0;
    send(4'h3, 1'b0, 1'b0);
    send(4'h9, 1'b1, 1'b1);
    check("out0_still_valid", 32'(out0_valid), 1);
    check("out0_still_3", 32'(out0_data), 32'h3);
    out0_ready = 1'b1;
    send(4'hC, 1'b1, 1'b1);
    send(4'hD, 1'b1, 1'b1);
    send(4'hE, 1'b1, 1'b1);

    // Flush after two words on CH0: counter restarts, four words go to out1
    send(4'h1, 1'b0, 1'b1);
    send(4'h2, 1'b0, 1'b1);
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    check("sel_after_flush", 32'(sel), 1);
    for (int i = 4; i <= 7; i++) send(WIDTH'(i), 1'b1, 1'b1);
    send(4'h8, 1'b0, 1'b1);

    // Flush coinciding with the wrapping word toggles once
    send(4'h9, 1'b0, 1'b1);
    send(4'hA, 1'b0, 1'b1);
    flush = 1'b1;
    send(4'hB, 1'b0, 1'b1);
    flush = 1'b0;
    check("sel_flush_at_wrap", 32'(sel), 1);
    send(4'hC, 1'b1, 1'b1);
    idle(1);

    // Reset mid-burst with out1 holding a word
    out1_ready = 1'b0;
    send(4'hD, 1'b1, 1'b1);
    rst = 1'b1;
    exp0.delete();
    exp1.delete();
    idle(1);
    rst = 1'b0;
    check("midrst_sel", 32'(sel), 0);
    check("midrst_out0_valid", 32'(out0_valid), 0);
    check("midrst_out1_valid", 32'(out1_valid), 0);
    check("midrst_out1_data", 32'(out1_data), 0);
    check("midrst_in_ready", 32'(in_ready), 1);
    out1_ready = 1'b1;
    for (int i = 1; i <= 4; i++) send(WIDTH'(i), 1'b0, 1'b1);
    send(4'h5, 1'b1, 1'b1);
    idle(3);

    check("exp0_drained", 32'(exp0.size()), 0);
    check("exp1_drained", 32'(exp1.size()), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/demux_scheduler.md
# demux_scheduler

Sequencing controller for the 1:2 demultiplexer datapath. It accepts a stream of data words on a single valid/ready input and routes them alternately to two consumers in fixed-size bursts, owning the demux select line. Each output channel has a one-entry holding register, so a stalled consumer never corrupts or loses data. The block sits between a single producer and two downstream consumers.

## Interface
Parameters:
- WIDTH, 4, data word width in bits (≥1)
- BURST, 4, words routed to one channel before select toggles (≥1)

Ports:
- clk  input  1  clock; single clock domain, rising edge
- rst  input  1  reset; synchronous, active-high
- in_valid  input  1  producer has a word
- in_data  input  WIDTH  producer word
- in_ready  output  1  block accepts in_data this cycle
- out0_valid  output  1  channel 0 holding register full
- out0_data  output  WIDTH  channel 0 word
- out0_ready  input  1  consumer 0 takes word
- out1_valid  output  1  channel 1 holding register full
- out1_data  output  WIDTH  channel 1 word
- out1_ready  input  1  consumer 1 takes word
- sel  output  1  current demux select (0 = channel 0, 1 = channel 1)
- flush  input  1  force select toggle after current cycle

## Operation
- State: sel register (states CH0, CH1), burst counter cnt (width clog2(BURST), min 1), two holding registers {valid, data}.
- Accept: acc = in_valid && in_ready. in_ready = !outS_valid || outS_ready, where S = sel (combinational from outS_ready).
- On acc, in_data loads into channel sel register, its valid set; other channel register untouched (demux: unselected output receives nothing).
- Channel k valid clears on outk_valid && outk_ready unless reloaded same cycle (reload wins, valid stays 1).
- Burst count: on acc, cnt increments; if cnt == BURST-1, cnt ← 0 and sel toggles next cycle.
- flush=1: sel toggles and cnt ← 0 next cycle regardless of cnt; a same-cycle acc still goes to old sel. flush with acc at cnt==BURST-1 toggles once only.
- Channel not selected keeps draining its held word independently.
- out_data holds last loaded value while valid=0 (not cleared on drain).

## Timing
- Reset values: sel=0, cnt=0, out0_valid=out1_valid=0, out0_data=out1_data=0; in_ready=1 once rst deasserts (combinational from empty register).
- rst mid-operation: held words discarded, all state to reset values next edge; rst dominates flush and acc.
- Latency: word accepted at edge n appears on outk_data with outk_valid=1 after edge n (visible cycle n+1).
- Throughput: one word per cycle sustained when selected consumer holds ready=1, including across a select toggle (no bubble).
- Selected register full and ready=0: in_ready=0, cnt and sel frozen (flush still honoured).
- BURST=1: sel toggles after every accepted word.

## Structure
- Package demux_pkg: select enum {CH0, CH1}; localparam for counter width helper.
- Sub-module demux_slot (one-entry holding register with load, valid/ready drain, WIDTH parameter), instantiated twice; controller holds sel, cnt, and in_ready logic.

## Test plan
- Reset: assert rst 2 cycles -> sel=0, both valid=0, data=0, in_ready=1.
- Streaming: WIDTH=4, BURST=4, both ready=1, feed 0x1..0x8 back-to-back -> 0x1–0x4 on out0, 0x5–0x8 on out1, each one cycle after accept, sel toggles after 4th word, no bubble.
- Backpressure: out0_ready=0, feed 0xA,0xB -> 0xA held on out0, in_ready=0, 0xB stalled; raise out0_ready -> 0xA drained and 0xB loaded same cycle, out0_valid stays 1.
- Independent drain: fill out0 with 0x3 (ready=0), reach toggle, feed 0x9 -> 0x9 on out1 while out0 still holds 0x3.
- Flush: after 2 words on CH0 pulse flush -> next word goes to out1, cnt restarts so 4 words go to out1.
- Reset mid-burst: after 3 words with out1 holding data, assert rst -> sel=0, cnt=0, both valid=0; next 4 words go to out0.
